// File: rtl/int_ctrl.sv
// Interrupt controller: synchronises external requests, injects an INT marker,
// follows the memory-stage PC/flags push, fetches the ISR vector and redirects the PC.
module int_ctrl #(
   parameter logic [31:0] VEC_ADDR    = 32'd2,
   parameter int          MEM_TIMEOUT = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        INT_req_in,
   input  logic        issue_ok_in,
   output logic        INT_out,
   input  logic        mem_int_in,
   input  logic        mem_stall_in,
   input  logic        rti_retire_in,
   output logic        vec_rd_out,
   output logic [31:0] vec_addr_out,
   input  logic [15:0] vec_data_in,
   output logic        PC_load_out,
   output logic [31:0] PC_val_out,
   output logic        busy_out,
   output logic        lost_out,
   output logic        err_out
);

   localparam logic [7:0] TIMEOUT_INIT = 8'(MEM_TIMEOUT);

   typedef enum logic [2:0] {IDLE, WAIT_MEM, PUSH, VEC_HI, VEC_LO, LOAD} state_t;

   state_t      state, state_nxt;
   logic        req_s1, req_s2, req_d;
   logic        req_edge;
   logic        pending, in_service;
   logic [7:0]  cnt, cnt_nxt;
   logic [15:0] hi, lo;
   logic        issue, err_set, svc_set;

   assign req_edge = req_s2 & ~req_d;
   assign busy_out = (state != IDLE) | in_service;

   always_comb begin
      state_nxt    = state;
      cnt_nxt      = cnt;
      INT_out      = 1'b0;
      vec_rd_out   = 1'b0;
      vec_addr_out = 32'd0;
      PC_load_out  = 1'b0;
      PC_val_out   = 32'd0;
      issue        = 1'b0;
      err_set      = 1'b0;
      svc_set      = 1'b0;
      case (state)
         IDLE: begin
            if (pending && !in_service && issue_ok_in) begin
               INT_out   = 1'b1;
               issue     = 1'b1;
               cnt_nxt   = TIMEOUT_INIT;
               state_nxt = WAIT_MEM;
            end
         end
         WAIT_MEM: begin
            if (mem_int_in) begin
               state_nxt = PUSH;
            end else begin
               cnt_nxt = cnt - 8'd1;
               // Counter reaching zero on this decrement ends the wait.
               if (cnt <= 8'd1) begin
                  err_set   = 1'b1;
                  state_nxt = IDLE;
               end
            end
         end
         PUSH: begin
            if (!mem_int_in) begin
               err_set   = 1'b1;
               state_nxt = IDLE;
            end else if (mem_stall_in) begin
               state_nxt = VEC_HI;
            end
         end
         VEC_HI: begin
            vec_rd_out   = 1'b1;
            vec_addr_out = VEC_ADDR;
            state_nxt    = VEC_LO;
         end
         VEC_LO: begin
            vec_rd_out   = 1'b1;
            vec_addr_out = VEC_ADDR + 32'd1;
            state_nxt    = LOAD;
         end
         LOAD: begin
            PC_load_out = 1'b1;
            PC_val_out  = {hi, lo};
            svc_set     = 1'b1;
            state_nxt   = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         cnt        <= 8'd0;
         hi         <= 16'd0;
         lo         <= 16'd0;
         req_s1     <= 1'b0;
         req_s2     <= 1'b0;
         req_d      <= 1'b0;
         pending    <= 1'b0;
         in_service <= 1'b0;
         lost_out   <= 1'b0;
         err_out    <= 1'b0;
      end else begin
         state  <= state_nxt;
         cnt    <= cnt_nxt;
         req_s1 <= INT_req_in;
         req_s2 <= req_s1;
         req_d  <= req_s2;
         if (state == VEC_HI) hi <= vec_data_in;
         if (state == VEC_LO) lo <= vec_data_in;
         // A new edge wins over consumption so a back-to-back request is kept.
         if (req_edge) pending <= 1'b1;
         else if (issue) pending <= 1'b0;
         if (req_edge && pending && !issue) lost_out <= 1'b1;
         if (err_set) err_out <= 1'b1;
         if (svc_set) in_service <= 1'b1;
         else if (rti_retire_in) in_service <= 1'b0;
      end
   end

endmodule

// File: tb/tb_int_ctrl.sv
// Directed bench for int_ctrl: cycle table for the basic sequence plus
// hand-written blocked-issue, timeout, reset, lost-request and wrap sequences.
module tb_int_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        INT_req_in, issue_ok_in, mem_int_in, mem_stall_in, rti_retire_in;
   logic        a_int, a_vrd, a_pcl, a_busy, a_lost, a_err;
   logic [31:0] a_vaddr, a_pcv;
   logic [15:0] a_vdata;
   logic        b_int, b_vrd, b_pcl, b_busy, b_lost, b_err;
   logic [31:0] b_vaddr, b_pcv;
   logic [15:0] b_vdata;

   int n_tests = 0;
   int n_fail  = 0;
   int int_cnt = 0;
   int pcl_cnt = 0;

   always #5 clk = ~clk;

   int_ctrl #(.VEC_ADDR(32'd2), .MEM_TIMEOUT(4)) dut_a (
      .clk(clk), .reset(reset), .INT_req_in(INT_req_in), .issue_ok_in(issue_ok_in),
      .INT_out(a_int), .mem_int_in(mem_int_in), .mem_stall_in(mem_stall_in),
      .rti_retire_in(rti_retire_in), .vec_rd_out(a_vrd), .vec_addr_out(a_vaddr),
      .vec_data_in(a_vdata), .PC_load_out(a_pcl), .PC_val_out(a_pcv),
      .busy_out(a_busy), .lost_out(a_lost), .err_out(a_err)
   );

   int_ctrl #(.VEC_ADDR(32'hFFFF_FFFF), .MEM_TIMEOUT(8)) dut_b (
      .clk(clk), .reset(reset), .INT_req_in(INT_req_in), .issue_ok_in(issue_ok_in),
      .INT_out(b_int), .mem_int_in(mem_int_in), .mem_stall_in(mem_stall_in),
      .rti_retire_in(rti_retire_in), .vec_rd_out(b_vrd), .vec_addr_out(b_vaddr),
      .vec_data_in(b_vdata), .PC_load_out(b_pcl), .PC_val_out(b_pcv),
      .busy_out(b_busy), .lost_out(b_lost), .err_out(b_err)
   );

   // Instruction memory models
   always_comb begin
      a_vdata = 16'hFFFF;
      if (a_vaddr == 32'd2) a_vdata = 16'h0000;
      else if (a_vaddr == 32'd3) a_vdata = 16'h0100;
   end

   always_comb begin
      b_vdata = 16'hEEEE;
      if (b_vrd && b_vaddr == 32'hFFFF_FFFF) b_vdata = 16'h1234;
      else if (b_vrd && b_vaddr == 32'd0) b_vdata = 16'h5678;
   end

   typedef struct {
      logic        req, ok, mi, ms, rti;
      logic        e_int, e_vrd;
      logic [31:0] e_vaddr;
      logic        e_pcl;
      logic [31:0] e_pcv;
      logic        e_busy;
   } vec_t;

   vec_t tbl [15];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // One clock cycle: drive inputs after the falling edge, then settle and count pulses.
   task automatic cyc(input logic r, input logic ok, input logic mi, input logic ms, input logic rt);
      @(negedge clk);
      INT_req_in    = r;
      issue_ok_in   = ok;
      mem_int_in    = mi;
      mem_stall_in  = ms;
      rti_retire_in = rt;
      #1;
      if (a_int) int_cnt++;
      if (a_pcl) pcl_cnt++;
   endtask

   task automatic pulse(input logic ok);
      cyc(1'b1, ok, 1'b0, 1'b0, 1'b0);
      cyc(1'b1, ok, 1'b0, 1'b0, 1'b0);
      cyc(1'b0, ok, 1'b0, 1'b0, 1'b0);
      cyc(1'b0, ok, 1'b0, 1'b0, 1'b0);
   endtask

   // From idle: request pulse with issue allowed; ends in the cycle INT_out should be high.
   task automatic req_issue(input string name);
      cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      check({name, ".int"}, a_int, 1'b1);
   endtask

   // Memory stage answering 3 cycles after INT_out; ends in the VEC_HI cycle.
   task automatic mem_push();
      cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
      cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic check_all_zero(input string name);
      check({name, ".int"},   a_int,   1'b0);
      check({name, ".vrd"},   a_vrd,   1'b0);
      check({name, ".vaddr"}, a_vaddr, 32'd0);
      check({name, ".pcl"},   a_pcl,   1'b0);
      check({name, ".pcv"},   a_pcv,   32'd0);
      check({name, ".busy"},  a_busy,  1'b0);
      check({name, ".lost"},  a_lost,  1'b0);
      check({name, ".err"},   a_err,   1'b0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
      $fatal(1);
   end

   initial begin
      int i0, p0, waitc;

      //             req   ok    mi    ms    rti   int   vrd   vaddr  pcl   pcv       busy
      tbl[0]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0,    1'b0};
      tbl[1]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0,    1'b0};
      tbl[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0,    1'b0};
      tbl[3]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0,    1'b0};
      tbl[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0,    1'b1};
      tbl[5]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0,    1'b1};
      tbl[6]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0,    1'b1};
      tbl[7]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0,    1'b1};
      tbl[8]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'd2, 1'b0, 32'd0,    1'b1};
      tbl[9]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'd3, 1'b0, 32'd0,    1'b1};
      tbl[10] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 32'h100,  1'b1};
      tbl[11] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0,    1'b1};
      tbl[12] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0,    1'b1};
      tbl[13] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0,    1'b1};
      tbl[14] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0,    1'b0};

      reset = 1'b0;
      INT_req_in = 1'b0; issue_ok_in = 1'b1; mem_int_in = 1'b0;
      mem_stall_in = 1'b0; rti_retire_in = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      check_all_zero("reset");
      @(negedge clk);
      reset = 1'b1;

      // Basic sequence, one row per cycle
      for (int i = 0; i < 15; i++) begin
         cyc(tbl[i].req, tbl[i].ok, tbl[i].mi, tbl[i].ms, tbl[i].rti);
         check($sformatf("basic[%0d].int", i),   a_int,   tbl[i].e_int);
         check($sformatf("basic[%0d].vrd", i),   a_vrd,   tbl[i].e_vrd);
         check($sformatf("basic[%0d].vaddr", i), a_vaddr, tbl[i].e_vaddr);
         check($sformatf("basic[%0d].pcl", i),   a_pcl,   tbl[i].e_pcl);
         check($sformatf("basic[%0d].pcv", i),   a_pcv,   tbl[i].e_pcv);
         check($sformatf("basic[%0d].busy", i),  a_busy,  tbl[i].e_busy);
      end
      check("basic.err", a_err, 1'b0);

      // Blocked issue, then timeout with no memory response
      i0 = int_cnt;
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      repeat (8) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      check("blocked.withheld", int_cnt - i0, 0);
      cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      check("blocked.first_ok", a_int, 1'b1);
      p0 = pcl_cnt;
      waitc = 0;
      for (int j = 0; j < 10; j++) begin
         cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
         if (a_busy) waitc++;
      end
      check("timeout.wait_cycles", waitc, 4);
      check("timeout.err", a_err, 1'b1);
      check("timeout.idle", a_busy, 1'b0);
      check("timeout.no_pcl", pcl_cnt - p0, 0);

      // Reset during VEC_LO
      req_issue("rst");
      mem_push();
      check("rst.vec_hi_addr", a_vaddr, 32'd2);
      cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      check("rst.vec_lo_addr", a_vaddr, 32'd3);
      reset = 1'b0;
      #1;
      check_all_zero("rst.async");
      @(negedge clk);
      reset = 1'b1;
      p0 = pcl_cnt;
      repeat (15) cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      check("rst.no_pcl", pcl_cnt - p0, 0);
      check("rst.idle", a_busy, 1'b0);

      // Lost requests and single reissue after RTI
      pulse(1'b0);
      check("lost.first", a_lost, 1'b0);
      pulse(1'b0);
      check("lost.second", a_lost, 1'b1);
      cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      check("lost.issue", a_int, 1'b1);
      mem_push();
      cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      check("lost.pcl", a_pcl, 1'b1);
      check("lost.pcv", a_pcv, 32'h100);
      i0 = int_cnt;
      pulse(1'b1);
      pulse(1'b1);
      check("lost.isr_blocked", int_cnt - i0, 0);
      check("lost.sticky", a_lost, 1'b1);
      check("lost.in_service", a_busy, 1'b1);
      cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
      check("lost.rti_cycle_int", a_int, 1'b0);
      cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      check("lost.after_rti", a_int, 1'b1);
      repeat (12) cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      check("lost.one_reissue", int_cnt - i0, 1);

      // Vector address wrap on the second instance
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      req_issue("wrap");
      mem_push();
      check("wrap.hi_rd", b_vrd, 1'b1);
      check("wrap.hi_addr", b_vaddr, 32'hFFFF_FFFF);
      cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      check("wrap.lo_addr", b_vaddr, 32'd0);
      cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      check("wrap.pcl", b_pcl, 1'b1);
      check("wrap.pcv", b_pcv, 32'h1234_5678);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/int_ctrl.md
# int_ctrl

Interrupt controller for the 5-stage pipelined processor. It is the initiator side of the interrupt protocol that the memory stage answers. It latches external interrupt requests and injects a one-cycle INT marker into the pipeline front end. It then tracks the memory stage's two-cycle PC/flags push, fetches the 32-bit ISR vector from instruction memory and redirects the PC. While an ISR is in service it blocks further interrupts until the RTI pop retires.

## Interface
- VEC_ADDR, 32'd2: instruction-memory word address of the ISR vector high half; the low half is at VEC_ADDR+1.
- MEM_TIMEOUT, 8: max cycles from INT_out to the INT marker reaching the memory stage; range 2..255.

- clk  in  1  pipeline clock, all state on rising edge
- reset  in  1  asynchronous, active-low; clears all state
- INT_req_in  in  1  external request, asynchronous, rising-edge sensitive
- issue_ok_in  in  1  front end can accept an injected INT this cycle (no flush, no stall)
- INT_out  out  1  one-cycle INT injection into IF/ID buffer
- mem_int_in  in  1  INT bit of the EX/MEM buffer, as seen by the memory stage
- mem_stall_in  in  1  memory-stage stall (high on the second push cycle)
- rti_retire_in  in  1  memory stage POP PC signal for RTI (PC reload from stack)
- vec_rd_out  out  1  instruction-memory read enable for the vector
- vec_addr_out  out  32  vector word address
- vec_data_in  in  16  instruction-memory word, combinational in the same cycle
- PC_load_out  out  1  one-cycle PC redirect
- PC_val_out  out  32  ISR address, valid when PC_load_out=1, else 0
- busy_out  out  1  sequence active or ISR in service
- lost_out  out  1  sticky: request dropped
- err_out  out  1  sticky: MEM_TIMEOUT expired

## Operation
- **Request capture**
  - INT_req_in passes through a 2-flop synchronizer, then a rising-edge detector.
  - A detected edge sets `pending`.
  - An edge while `pending`=1 and not being consumed that cycle sets lost_out.
  - An edge in the same cycle `pending` is consumed leaves `pending`=1.
- **FSM states:** IDLE, WAIT_MEM, PUSH, VEC_HI, VEC_LO, LOAD.
- **IDLE:** when `pending` & !`in_service` & issue_ok_in, drive INT_out=1, clear `pending`, load timeout counter = MEM_TIMEOUT, go to WAIT_MEM. Otherwise stay.
- **WAIT_MEM:**
  - mem_int_in=1 -> PUSH.
  - Otherwise decrement the counter. At 0, set err_out and go to IDLE; `in_service` is unchanged.
- **PUSH:** wait for mem_int_in=1 & mem_stall_in=1, which marks the second push cycle (PC low half written) -> VEC_HI. mem_int_in falling before that sets err_out -> IDLE.
- **VEC_HI:** vec_rd_out=1, vec_addr_out=VEC_ADDR, capture vec_data_in into `hi` -> VEC_LO.
- **VEC_LO:** vec_rd_out=1, vec_addr_out=VEC_ADDR+1 (32-bit add, wraps), capture into `lo` -> LOAD.
- **LOAD:** PC_load_out=1, PC_val_out={hi,lo}, set `in_service` -> IDLE.
- **ISR end:** rti_retire_in=1 clears `in_service`; ignored when `in_service`=0. If rti_retire_in and an IDLE issue condition coincide, no issue that cycle; issue on the next eligible cycle.
- **Outputs:** busy_out = (state != IDLE) | `in_service`. vec_addr_out=0 when vec_rd_out=0.
- **Reset:** reset low at any time forces IDLE immediately, including mid-sequence. It clears `pending`, `in_service`, lost_out, err_out, the synchronizer and edge register, `hi`/`lo` and the counter. No partial redirect is emitted.

## Timing
- Reset values: every output 0.
- Request to INT_out: INT_req_in high before edge k gives `pending` after edge k+2. INT_out is high in the cycle after edge k+2 if issue_ok_in=1 and the controller is idle.
- INT_out and PC_load_out are always exactly one cycle wide.
- From PUSH exit, VEC_HI, VEC_LO and LOAD occupy 3 consecutive cycles. PC_load_out is asserted 3 cycles after the mem_stall_in=1 cycle.
- No interrupt nesting: at most one sequence plus one pending request at any time.

## Test plan
- **Basic:** VEC_ADDR=2, vec words 0x0000/0x0100, request pulse, issue_ok_in=1, MEM model asserts mem_int_in 3 cycles after INT_out for 2 cycles with mem_stall_in on the second -> INT_out one cycle at cycle 3, PC_load_out=1 with PC_val_out=0x00000100, busy_out stays 1 until rti_retire_in.
- **Blocked issue:** issue_ok_in=0 for 10 cycles while pending -> INT_out withheld, then fires the first cycle issue_ok_in=1.
- **Lost:** second edge while pending -> lost_out=1; third edge during ISR with `pending` already set -> lost_out stays 1 and only one further INT_out follows rti_retire_in.
- **Timeout:** MEM_TIMEOUT=4, no mem_int_in -> err_out=1 after 4 WAIT_MEM cycles, FSM in IDLE, no PC_load_out.
- **Reset mid-sequence:** reset low during VEC_LO -> all outputs 0 immediately; after release, no PC_load_out until a new request.
- **Wrap:** VEC_ADDR=32'hFFFFFFFF -> VEC_LO reads address 0.
